// File: rtl/kyogenrv_arb_pkg.sv
// Shared types and constants for the KyogenRV two-master Avalon-MM arbiter.
package kyogenrv_arb_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCmd  = 2'd1,
      StRdw  = 2'd2
   } arb_state_e;

   typedef enum logic {
      Master0 = 1'b0,
      Master1 = 1'b1
   } master_id_e;

   localparam logic [31:0] ARB_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/kyogenrv_rr_pick.sv
// Two-way round-robin pick: a sole requester wins, a tie goes to the master
// that did not win last time.
module kyogenrv_rr_pick
   import kyogenrv_arb_pkg::*;
(
   input  logic [1:0] req,
   input  master_id_e last_grant,
   output master_id_e grant
);

   always_comb begin
      grant = Master0;
      unique case (req)
         2'b10:   grant = Master1;
         2'b11:   grant = (last_grant == Master0) ? Master1 : Master0;
         default: grant = Master0;
      endcase
   end

endmodule

// File: rtl/kyogenrv_avmm_arb2.sv
// Two-master (CPU data / debug loader) to one-slave Avalon-MM arbiter, one
// transaction in flight. KYOGENRV_ARB_TIMEOUT_EN compiles in the watchdog.
module kyogenrv_avmm_arb2
   import kyogenrv_arb_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 256
) (
   input  logic                clk_riscv,
   input  logic                rst_in,

   input  logic [ADDR_W-1:0]   m0_address,
   input  logic [DATA_W-1:0]   m0_writedata,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic                m0_read,
   input  logic                m0_write,
   output logic                m0_waitrequest,
   output logic                m0_readdatavalid,
   output logic [DATA_W-1:0]   m0_readdata,

   input  logic [ADDR_W-1:0]   m1_address,
   input  logic [DATA_W-1:0]   m1_writedata,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic                m1_read,
   input  logic                m1_write,
   output logic                m1_waitrequest,
   output logic                m1_readdatavalid,
   output logic [DATA_W-1:0]   m1_readdata,

   output logic [ADDR_W-1:0]   s_address,
   output logic [DATA_W-1:0]   s_writedata,
   output logic [DATA_W/8-1:0] s_byteenable,
   output logic                s_read,
   output logic                s_write,
   input  logic                s_waitrequest,
   input  logic                s_readdatavalid,
   input  logic [DATA_W-1:0]   s_readdata,

   output logic                err_timeout
);

   arb_state_e  state_q, state_d;
   master_id_e  owner_q, owner_d;
   master_id_e  last_grant_q, last_grant_d;
   master_id_e  pick;

   logic              g_read, g_write;
   logic              cmd_wait;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              tmo_hit;
   logic              rd_abort;
   logic              err_set;
   logic              abort_set;

   kyogenrv_rr_pick u_rr_pick (
      .req        ({m1_read | m1_write, m0_read | m0_write}),
      .last_grant (last_grant_q),
      .grant      (pick)
   );

   // The slave bus always carries the owner's command; strobes gate it.
   assign s_address    = (owner_q == Master1) ? m1_address    : m0_address;
   assign s_writedata  = (owner_q == Master1) ? m1_writedata  : m0_writedata;
   assign s_byteenable = (owner_q == Master1) ? m1_byteenable : m0_byteenable;
   assign g_write      = (owner_q == Master1) ? m1_write      : m0_write;
   assign g_read       = ((owner_q == Master1) ? m1_read : m0_read) & ~g_write;

   assign s_write = (state_q == StCmd) & g_write;
   assign s_read  = (state_q == StCmd) & g_read;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      cmd_wait     = 1'b1;
      rd_valid     = 1'b0;
      rd_data      = s_readdata;
      err_set      = 1'b0;
      abort_set    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (m0_read | m0_write | m1_read | m1_write) begin
               owner_d      = pick;
               last_grant_d = pick;
               state_d      = StCmd;
            end
         end
         StCmd: begin
            cmd_wait = s_waitrequest;
            if (!(g_read | g_write)) begin
               state_d = StIdle;
            end else if (!s_waitrequest) begin
               state_d = g_write ? StIdle : StRdw;
            end else if (tmo_hit) begin
               // Release the master; a stuck read still owes it a data beat.
               cmd_wait  = 1'b0;
               err_set   = 1'b1;
               abort_set = g_read;
               state_d   = g_write ? StIdle : StRdw;
            end
         end
         StRdw: begin
            if (rd_abort) begin
               rd_valid = 1'b1;
               rd_data  = DATA_W'(ARB_TIMEOUT_DATA);
               state_d  = StIdle;
            end else if (s_readdatavalid) begin
               rd_valid = 1'b1;
               state_d  = StIdle;
            end else if (tmo_hit) begin
               rd_valid = 1'b1;
               rd_data  = DATA_W'(ARB_TIMEOUT_DATA);
               err_set  = 1'b1;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign m0_waitrequest   = (owner_q == Master0) ? cmd_wait : 1'b1;
   assign m1_waitrequest   = (owner_q == Master1) ? cmd_wait : 1'b1;
   assign m0_readdatavalid = rd_valid & (owner_q == Master0);
   assign m1_readdatavalid = rd_valid & (owner_q == Master1);
   assign m0_readdata      = m0_readdatavalid ? rd_data : '0;
   assign m1_readdata      = m1_readdatavalid ? rd_data : '0;

   always_ff @(posedge clk_riscv or negedge rst_in) begin
      if (!rst_in) begin
         state_q      <= StIdle;
         owner_q      <= Master0;
         last_grant_q <= Master1;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
      end
   end

`ifdef KYOGENRV_ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYC) + 1;

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            counting;
   logic            err_q;
   logic            abort_q;

   assign counting = ((state_q == StCmd) && s_waitrequest) || (state_q == StRdw);
   assign tmo_hit  = counting && (cnt_q == CntW'(TIMEOUT_CYC - 1));
   assign rd_abort = abort_q;

   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (counting) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk_riscv or negedge rst_in) begin
      if (!rst_in) begin
         cnt_q   <= '0;
         err_q   <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         err_q   <= err_q | err_set;
         abort_q <= abort_set;
      end
   end

   assign err_timeout = err_q;
`else
   logic unused_cfg;

   assign tmo_hit     = 1'b0;
   assign rd_abort    = 1'b0;
   assign err_timeout = 1'b0;
   assign unused_cfg  = ^{TIMEOUT_CYC, err_set, abort_set};
`endif

endmodule

// File: tb/tb_kyogenrv_avmm_arb2.sv
// Directed bench for kyogenrv_avmm_arb2; the watchdog scenario runs only when
// KYOGENRV_ARB_TIMEOUT_EN is defined.
module tb_kyogenrv_avmm_arb2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] m0_address, m0_writedata, m1_address, m1_writedata;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic        m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
   logic [31:0] m0_readdata, m1_readdata;
   logic [31:0] s_address, s_writedata, s_readdata;
   logic [3:0]  s_byteenable;
   logic        s_read, s_write, s_waitrequest, s_readdatavalid;
   logic        err_timeout;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   kyogenrv_avmm_arb2 #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk_riscv        (clk),
      .rst_in           (rst_n),
      .m0_address       (m0_address),
      .m0_writedata     (m0_writedata),
      .m0_byteenable    (m0_byteenable),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdatavalid (m0_readdatavalid),
      .m0_readdata      (m0_readdata),
      .m1_address       (m1_address),
      .m1_writedata     (m1_writedata),
      .m1_byteenable    (m1_byteenable),
      .m1_read          (m1_read),
      .m1_write         (m1_write),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdatavalid (m1_readdatavalid),
      .m1_readdata      (m1_readdata),
      .s_address        (s_address),
      .s_writedata      (s_writedata),
      .s_byteenable     (s_byteenable),
      .s_read           (s_read),
      .s_write          (s_write),
      .s_waitrequest    (s_waitrequest),
      .s_readdatavalid  (s_readdatavalid),
      .s_readdata       (s_readdata),
      .err_timeout      (err_timeout)
   );

   task automatic test_reset();
      rst_n = 1'b0;
      m0_address = '0; m0_writedata = '0; m0_byteenable = 4'hF; m0_read = 0; m0_write = 0;
      m1_address = '0; m1_writedata = '0; m1_byteenable = 4'hF; m1_read = 0; m1_write = 0;
      s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = '0;
      #2;
      vectors++; if (m0_waitrequest !== 1'b1) begin miscompares++; $display("FAIL rst_m0_wait: got %b want 1", m0_waitrequest); end
      vectors++; if (m1_waitrequest !== 1'b1) begin miscompares++; $display("FAIL rst_m1_wait: got %b want 1", m1_waitrequest); end
      vectors++; if ({s_read, s_write} !== 2'b00) begin miscompares++; $display("FAIL rst_s_strobes: got %b want 00", {s_read, s_write}); end
      vectors++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin miscompares++; $display("FAIL rst_rdv: got %b want 00", {m0_readdatavalid, m1_readdatavalid}); end
      vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b want 0", err_timeout); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_write();
      @(negedge clk);
      m0_write = 1; m0_address = 32'h10; m0_writedata = 32'h55; m0_byteenable = 4'hF;
      s_waitrequest = 0;
      #1;
      vectors++; if (s_write !== 1'b0) begin miscompares++; $display("FAIL wr_t_s_write: got %b want 0", s_write); end
      vectors++; if (m0_waitrequest !== 1'b1) begin miscompares++; $display("FAIL wr_t_m0_wait: got %b want 1", m0_waitrequest); end
      @(negedge clk); #1;
      vectors++; if (s_write !== 1'b1) begin miscompares++; $display("FAIL wr_t1_s_write: got %b want 1", s_write); end
      vectors++; if (s_address !== 32'h10) begin miscompares++; $display("FAIL wr_t1_addr: got %h want 00000010", s_address); end
      vectors++; if (s_writedata !== 32'h55) begin miscompares++; $display("FAIL wr_t1_data: got %h want 00000055", s_writedata); end
      vectors++; if (m0_waitrequest !== 1'b0) begin miscompares++; $display("FAIL wr_t1_m0_wait: got %b want 0", m0_waitrequest); end
      vectors++; if (m1_waitrequest !== 1'b1) begin miscompares++; $display("FAIL wr_t1_m1_wait: got %b want 1", m1_waitrequest); end
      @(negedge clk); m0_write = 0; #1;
      vectors++; if (s_write !== 1'b0) begin miscompares++; $display("FAIL wr_t2_s_write: got %b want 0", s_write); end
      vectors++; if (m0_waitrequest !== 1'b1) begin miscompares++; $display("FAIL wr_t2_m0_wait: got %b want 1", m0_waitrequest); end
   endtask

   task automatic test_read_write_both();
      @(negedge clk);
      m1_read = 1; m1_write = 1; m1_address = 32'h44; m1_writedata = 32'h9;
      @(negedge clk); #1;
      vectors++; if ({s_write, s_read} !== 2'b10) begin miscompares++; $display("FAIL both_strobes: got %b want 10", {s_write, s_read}); end
      vectors++; if (m1_waitrequest !== 1'b0) begin miscompares++; $display("FAIL both_m1_wait: got %b want 0", m1_waitrequest); end
      @(negedge clk); m1_read = 0; m1_write = 0; s_readdatavalid = 1; s_readdata = 32'h66; #1;
      vectors++; if (m1_readdatavalid !== 1'b0) begin miscompares++; $display("FAIL both_no_rdv: got %b want 0", m1_readdatavalid); end
      vectors++; if (m1_waitrequest !== 1'b1) begin miscompares++; $display("FAIL both_idle_wait: got %b want 1", m1_waitrequest); end
      s_readdatavalid = 0;
   endtask

   task automatic test_drop();
      @(negedge clk); s_waitrequest = 1; m0_read = 1; m0_address = 32'h20;
      @(negedge clk); #1;
      vectors++; if (s_read !== 1'b1) begin miscompares++; $display("FAIL drop_s_read: got %b want 1", s_read); end
      vectors++; if (m0_waitrequest !== 1'b1) begin miscompares++; $display("FAIL drop_m0_wait: got %b want 1", m0_waitrequest); end
      @(negedge clk); m0_read = 0; #1;
      vectors++; if (s_read !== 1'b0) begin miscompares++; $display("FAIL drop_s_read_off: got %b want 0", s_read); end
      @(negedge clk); s_waitrequest = 0; #1;
      vectors++; if (m0_waitrequest !== 1'b1) begin miscompares++; $display("FAIL drop_idle_wait: got %b want 1", m0_waitrequest); end
      vectors++; if ({s_read, s_write} !== 2'b00) begin miscompares++; $display("FAIL drop_idle_strobes: got %b want 00", {s_read, s_write}); end
   endtask

   task automatic test_spurious_rdv();
      @(negedge clk); s_readdatavalid = 1; s_readdata = 32'h99; #1;
      vectors++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin miscompares++; $display("FAIL spur_rdv: got %b want 00", {m0_readdatavalid, m1_readdatavalid}); end
      vectors++; if (m0_readdata !== 32'h0) begin miscompares++; $display("FAIL spur_m0_data: got %h want 0", m0_readdata); end
      @(negedge clk); #1;
      vectors++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin miscompares++; $display("FAIL spur_rdv2: got %b want 00", {m0_readdatavalid, m1_readdatavalid}); end
      s_readdatavalid = 0;
   endtask

   task automatic test_round_robin();
      logic [31:0] exp_addr;
      logic [31:0] exp_data;
      logic        own_m1;
      @(negedge clk); rst_n = 0;
      m0_read = 1; m0_address = 32'h100; m1_read = 1; m1_address = 32'h200; s_waitrequest = 0;
      @(negedge clk); rst_n = 1;
      for (int n = 0; n < 4; n++) begin
         own_m1   = (n % 2) == 1;
         exp_addr = own_m1 ? 32'h200 : 32'h100;
         exp_data = 32'hA0 + 32'(n);
         #1;
         vectors++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin miscompares++; $display("FAIL rr%0d_idle_wait: got %b want 11", n, {m0_waitrequest, m1_waitrequest}); end
         @(negedge clk); #1;
         vectors++; if (s_address !== exp_addr || s_read !== 1'b1) begin miscompares++; $display("FAIL rr%0d_grant: got addr %h read %b want %h 1", n, s_address, s_read, exp_addr); end
         vectors++; if ({m1_waitrequest, m0_waitrequest} !== (own_m1 ? 2'b01 : 2'b10)) begin miscompares++; $display("FAIL rr%0d_wait: got m1/m0 %b", n, {m1_waitrequest, m0_waitrequest}); end
         @(negedge clk); s_readdatavalid = 1; s_readdata = exp_data; #1;
         vectors++; if ({m1_readdatavalid, m0_readdatavalid} !== (own_m1 ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL rr%0d_rdv: got m1/m0 %b", n, {m1_readdatavalid, m0_readdatavalid}); end
         vectors++; if ((own_m1 ? m1_readdata : m0_readdata) !== exp_data) begin miscompares++; $display("FAIL rr%0d_data: got %h want %h", n, own_m1 ? m1_readdata : m0_readdata, exp_data); end
         @(negedge clk); s_readdatavalid = 0;
      end
      m0_read = 0; m1_read = 0;
   endtask

   task automatic test_back_to_back();
      @(negedge clk); m1_read = 1; m1_address = 32'h300;
      @(negedge clk); #1;
      vectors++; if (m1_waitrequest !== 1'b0 || s_address !== 32'h300) begin miscompares++; $display("FAIL b2b_m1_cmd: got wait %b addr %h want 0 300", m1_waitrequest, s_address); end
      @(negedge clk); m1_read = 0; m0_read = 1; m0_address = 32'h100;
      for (int c = 1; c <= 4; c++) begin
         if (c > 1) @(negedge clk);
         #1;
         vectors++; if (m0_waitrequest !== 1'b1 || m1_readdatavalid !== 1'b0) begin miscompares++; $display("FAIL b2b_wait%0d: got m0 wait %b m1 rdv %b want 1 0", c, m0_waitrequest, m1_readdatavalid); end
      end
      @(negedge clk); s_readdatavalid = 1; s_readdata = 32'h77; #1;
      vectors++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'h77) begin miscompares++; $display("FAIL b2b_m1_rdv: got %b %h want 1 00000077", m1_readdatavalid, m1_readdata); end
      vectors++; if (m0_waitrequest !== 1'b1 || m0_readdatavalid !== 1'b0) begin miscompares++; $display("FAIL b2b_m0_hold: got wait %b rdv %b want 1 0", m0_waitrequest, m0_readdatavalid); end
      @(negedge clk); s_readdatavalid = 0; #1;
      vectors++; if (m0_waitrequest !== 1'b1 || s_read !== 1'b0) begin miscompares++; $display("FAIL b2b_idle: got wait %b read %b want 1 0", m0_waitrequest, s_read); end
      @(negedge clk); #1;
      vectors++; if (m0_waitrequest !== 1'b0 || s_address !== 32'h100 || s_read !== 1'b1) begin miscompares++; $display("FAIL b2b_m0_grant: got wait %b addr %h read %b want 0 100 1", m0_waitrequest, s_address, s_read); end
      @(negedge clk); m0_read = 0; s_readdatavalid = 1; s_readdata = 32'h12; #1;
      vectors++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h12) begin miscompares++; $display("FAIL b2b_m0_rdv: got %b %h want 1 00000012", m0_readdatavalid, m0_readdata); end
      @(negedge clk); s_readdatavalid = 0;
   endtask

   task automatic test_reset_in_rdw();
      @(negedge clk); m0_read = 1; m0_address = 32'h100;
      @(negedge clk);
      @(negedge clk); m0_read = 0;
      #2; rst_n = 0; s_readdatavalid = 1; s_readdata = 32'h33; #1;
      vectors++; if (m0_readdatavalid !== 1'b0 || m0_readdata !== 32'h0) begin miscompares++; $display("FAIL rrdw_no_rdv: got %b %h want 0 0", m0_readdatavalid, m0_readdata); end
      vectors++; if (m0_waitrequest !== 1'b1 || s_read !== 1'b0) begin miscompares++; $display("FAIL rrdw_idle: got wait %b read %b want 1 0", m0_waitrequest, s_read); end
      @(negedge clk); rst_n = 1; s_readdatavalid = 0; m0_read = 1; m1_read = 1;
      m1_address = 32'h200; #1;
      vectors++; if (m0_readdatavalid !== 1'b0) begin miscompares++; $display("FAIL rrdw_no_rdv2: got %b want 0", m0_readdatavalid); end
      @(negedge clk); #1;
      vectors++; if (s_address !== 32'h100 || m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin miscompares++; $display("FAIL rrdw_tie_m0: got addr %h m0w %b m1w %b want 100 0 1", s_address, m0_waitrequest, m1_waitrequest); end
      @(negedge clk); m0_read = 0; m1_read = 0; s_readdatavalid = 1; s_readdata = 32'h0;
      @(negedge clk); s_readdatavalid = 0;
   endtask

`ifdef KYOGENRV_ARB_TIMEOUT_EN
   task automatic test_timeout();
      @(negedge clk); m0_read = 1; m0_address = 32'h400; s_waitrequest = 0;
      @(negedge clk);
      @(negedge clk); m0_read = 0;
      for (int c = 1; c <= 16; c++) begin
         if (c > 1) @(negedge clk);
         #1;
         if (c < 16) begin
            vectors++; if (m0_readdatavalid !== 1'b0) begin miscompares++; $display("FAIL tmo_early%0d: got rdv %b want 0", c, m0_readdatavalid); end
         end else begin
            vectors++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL tmo_data: got %b %h want 1 deadbeef", m0_readdatavalid, m0_readdata); end
         end
      end
      @(negedge clk); #1;
      vectors++; if (err_timeout !== 1'b1) begin miscompares++; $display("FAIL tmo_err: got %b want 1", err_timeout); end
      vectors++; if (m0_readdatavalid !== 1'b0) begin miscompares++; $display("FAIL tmo_one_pulse: got %b want 0", m0_readdatavalid); end
   endtask
`else
   task automatic test_no_timeout();
      #1;
      vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL notmo_err: got %b want 0", err_timeout); end
   endtask
`endif

   initial begin
      test_reset();
      test_write();
      test_read_write_both();
      test_drop();
      test_spurious_rdv();
      test_round_robin();
      test_back_to_back();
      test_reset_in_rdw();
`ifdef KYOGENRV_ARB_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
